fnd_scan: RTL and testbench

FND_SCAN -- requirements
Module: fnd_scan

---
 rtl/fnd_scan.sv | 178 +++++++++++++++++
 tb/tb_fnd_scan.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fnd_scan.sv
// fnd_scan: multiplexed 7-segment display scanner with per-slot anti-ghost blanking.
// Each digit slot is BLANK_CYC blank cycles followed by the lit phase. The slot is
// SCAN_DIV cycles long. The segment pattern is latched once per slot.
// Optional decimal-point support is enabled by defining the macro FND_DP_EN.
module fnd_scan #(
  parameter int unsigned NUM_DIG     = 4,
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned BLANK_CYC   = 1000,
  parameter int unsigned SEG_ACT_LOW = 0
) (
  input  logic                 iCLK,
  input  logic                 inReset,
  input  logic                 iEn,
  input  logic [7*NUM_DIG-1:0] iSeg,
`ifdef FND_DP_EN
  input  logic [NUM_DIG-1:0]   iDp,
`endif
  output logic [NUM_DIG-1:0]   oSel,
  output logic [6:0]           oSeg,
`ifdef FND_DP_EN
  output logic                 oDp,
`endif
  output logic                 oFrame
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned IDX_W = $clog2(NUM_DIG);

  localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIG - 1);
  localparam logic [6:0]         SEG_OFF    = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic               DP_OFF     = (SEG_ACT_LOW != 0);
  localparam logic [NUM_DIG-1:0] SEL_ONE    = NUM_DIG'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [6:0]         snap_seg_q, snap_seg_d;
`ifdef FND_DP_EN
  logic               snap_dp_q, snap_dp_d;
  logic               dp_q, dp_d;
`endif
  logic [NUM_DIG-1:0] sel_q, sel_d;
  logic [6:0]         seg_q, seg_d;
  logic               frame_q, frame_d;

  logic [6:0]         dig_seg [NUM_DIG];

  // Split the flat segment bus into one pattern per digit
  always_comb begin
    for (int k = 0; k < int'(NUM_DIG); k++) begin
      dig_seg[k] = iSeg[7*k +: 7];
    end
  end

  // State, slot counter, digit index and snapshot registers
  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      snap_seg_q <= '0;
`ifdef FND_DP_EN
      snap_dp_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_seg_q <= snap_seg_d;
`ifdef FND_DP_EN
      snap_dp_q  <= snap_dp_d;
`endif
    end
  end

  // Next state: slot sequencing, digit advance and snapshot capture on BLANK->ON
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    snap_seg_d = snap_seg_q;
`ifdef FND_DP_EN
    snap_dp_d  = snap_dp_q;
`endif
    if (!iEn) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
        BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) begin
            state_d    = ON;
            snap_seg_d = dig_seg[idx_q];
`ifdef FND_DP_EN
            snap_dp_d  = iDp[idx_q];
`endif
          end
        end
        ON: begin
          if (cnt_q == SLOT_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the pins track the state register
  always_comb begin
    sel_d   = '0;
    seg_d   = SEG_OFF;
    frame_d = 1'b0;
`ifdef FND_DP_EN
    dp_d    = DP_OFF;
`endif
    if (state_d == ON) begin
      sel_d = SEL_ONE << idx_d;
      seg_d = snap_seg_d ^ SEG_OFF;
`ifdef FND_DP_EN
      dp_d  = snap_dp_d ^ DP_OFF;
`endif
    end
    if ((state_d == BLANK) && (cnt_d == '0) && (idx_d == '0)) begin
      frame_d = 1'b1;
    end
  end

  // Output registers; reset drives the display dark
  always_ff @(posedge iCLK or negedge inReset) begin
    if (!inReset) begin
      sel_q   <= '0;
      seg_q   <= SEG_OFF;
      frame_q <= 1'b0;
`ifdef FND_DP_EN
      dp_q    <= DP_OFF;
`endif
    end else begin
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      frame_q <= frame_d;
`ifdef FND_DP_EN
      dp_q    <= dp_d;
`endif
    end
  end

  assign oSel   = sel_q;
  assign oSeg   = seg_q;
  assign oFrame = frame_q;
`ifdef FND_DP_EN
  assign oDp    = dp_q;
`endif

endmodule

// File: tb/tb_fnd_scan.sv
// tb_fnd_scan: directed bench for fnd_scan with a slot-arithmetic reference model.
// Two instances share stimulus: active-high and active-low segment polarity.
module tb_fnd_scan;

  localparam int ND = 4;
  localparam int SD = 10;
  localparam int BC = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        ien   = 1'b0;
  logic [27:0] iseg;
`ifdef FND_DP_EN
  logic [3:0]  idp;
  logic        dp0, dp1;
  logic        m_snap_dp;
`endif
  logic [3:0]  sel0, sel1;
  logic [6:0]  seg0, seg1;
  logic        fr0, fr1;

  int n_chk = 0;
  int n_err = 0;
  int k     = 0;
  int nfr   = 0;

  // reference model state: time since enable, captured pattern
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [6:0]  m_snap;

  always #5 clk = ~clk;

  fnd_scan #(.NUM_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_ACT_LOW(0)) u_dut (
    .iCLK(clk), .inReset(rst_n), .iEn(ien), .iSeg(iseg),
`ifdef FND_DP_EN
    .iDp(idp), .oDp(dp0),
`endif
    .oSel(sel0), .oSeg(seg0), .oFrame(fr0)
  );

  fnd_scan #(.NUM_DIG(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .SEG_ACT_LOW(1)) u_dut_al (
    .iCLK(clk), .inReset(rst_n), .iEn(ien), .iSeg(iseg),
`ifdef FND_DP_EN
    .iDp(idp), .oDp(dp1),
`endif
    .oSel(sel1), .oSeg(seg1), .oFrame(fr1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int nxt_t();
    return m_active ? m_t + 1 : 0;
  endfunction

  function automatic logic [6:0] dseg(input int d);
    logic [27:0] t;
    t = iseg >> (7 * d);
    return t[6:0];
  endfunction

  // model: the enabled run is a sequence of SD-cycle slots cycling through ND digits
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_t      <= 0;
      m_snap   <= 7'h00;
`ifdef FND_DP_EN
      m_snap_dp <= 1'b0;
`endif
    end else if (!ien) begin
      m_active <= 1'b0;
      m_t      <= 0;
    end else begin
      m_active <= 1'b1;
      m_t      <= nxt_t();
      if (nxt_t() % SD == BC) begin
        m_snap <= dseg((nxt_t() / SD) % ND);
`ifdef FND_DP_EN
        m_snap_dp <= idp[(nxt_t() / SD) % ND];
`endif
      end
    end
  end

  // compare both instances against the model every cycle
  always @(posedge clk) begin : cmp
    int         pos, dig;
    bit         on;
    logic [3:0] esel;
    logic [6:0] eseg;
    logic       efr;
    #2;
    pos  = m_t % SD;
    dig  = (m_t / SD) % ND;
    on   = m_active && (pos >= BC);
    esel = 4'b0000;
    if (on) esel[dig] = 1'b1;
    eseg = on ? m_snap : 7'h00;
    efr  = m_active && (pos == 0) && (dig == 0);
    chk("sel", 32'(sel0), 32'(esel));
    chk("seg", 32'(seg0), 32'(eseg));
    chk("frame", 32'(fr0), 32'(efr));
    chk("sel_al", 32'(sel1), 32'(esel));
    chk("seg_al", 32'(seg1), 32'(eseg ^ 7'h7F));
    chk("frame_al", 32'(fr1), 32'(efr));
    chk("onehot", 32'($countones(sel0) <= 1), 32'd1);
`ifdef FND_DP_EN
    chk("dp", 32'(dp0), 32'(on && m_snap_dp));
    chk("dp_al", 32'(dp1), 32'(!(on && m_snap_dp)));
`endif
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      k++;
    end
  endtask

  initial begin
    iseg = {7'h06, 7'h5B, 7'h4F, 7'h66};
`ifdef FND_DP_EN
    idp = 4'b0100;
`endif
    #3 rst_n = 1'b0;
    step(3);
    chk("rst_sel", 32'(sel0), 32'h0);
    chk("rst_seg", 32'(seg0), 32'h00);
    chk("rst_frame", 32'(fr0), 32'h0);
    chk("rst_seg_al", 32'(seg1), 32'h7F);
`ifdef FND_DP_EN
    chk("rst_dp_al", 32'(dp1), 32'h1);
`endif
    @(negedge clk) rst_n = 1'b1;
    step(2);
    chk("idle_sel", 32'(sel0), 32'h0);
    chk("idle_frame", 32'(fr0), 32'h0);

    // first frame plus the start of the second
    @(negedge clk) ien = 1'b1;
    k = -1;
    for (int i = 0; i < 41; i++) begin
      step(1);
      if (k >= 1 && fr0) nfr++;
      case (k)
        0:  begin chk("k0_frame", 32'(fr0), 32'h1); chk("k0_sel", 32'(sel0), 32'h0); end
        1:  chk("k1_sel", 32'(sel0), 32'h0);
        2:  begin
              chk("k2_sel", 32'(sel0), 32'h1);
              chk("k2_seg", 32'(seg0), 32'h66);
              chk("k2_seg_al", 32'(seg1), 32'h19);
            end
        9:  chk("k9_sel", 32'(sel0), 32'h1);
        10: begin chk("k10_sel", 32'(sel0), 32'h0); chk("k10_frame", 32'(fr0), 32'h0); end
        12: begin chk("k12_sel", 32'(sel0), 32'h2); chk("k12_seg", 32'(seg0), 32'h4F); end
        35: begin chk("k35_sel", 32'(sel0), 32'h8); chk("k35_seg", 32'(seg0), 32'h06); end
        40: chk("k40_frame", 32'(fr0), 32'h1);
        default: ;
      endcase
    end
    chk("frames_per_40", 32'(nfr), 32'd1);

    // pattern change in the middle of digit 1's lit phase
    step(14);
    chk("d1_sel", 32'(sel0), 32'h2);
    chk("d1_seg", 32'(seg0), 32'h4F);
    @(negedge clk) iseg[13:7] = 7'h7F;
    step(5);
    chk("hold_seg", 32'(seg0), 32'h4F);
    step(1);
    chk("d1_end_sel", 32'(sel0), 32'h0);
    step(32);
    chk("d1_next_sel", 32'(sel0), 32'h2);
    chk("d1_next_seg", 32'(seg0), 32'h7F);

    // disable in the middle of digit 2's lit phase
    step(14);
    chk("d2_sel", 32'(sel0), 32'h4);
    chk("d2_seg", 32'(seg0), 32'h5B);
`ifdef FND_DP_EN
    chk("d2_dp_al", 32'(dp1), 32'h0);
    chk("d2_dp", 32'(dp0), 32'h1);
`endif
    @(negedge clk) ien = 1'b0;
    step(1);
    chk("dis_sel", 32'(sel0), 32'h0);
    chk("dis_seg", 32'(seg0), 32'h00);
`ifdef FND_DP_EN
    chk("dis_dp_al", 32'(dp1), 32'h1);
`endif
    step(2);
    @(negedge clk) ien = 1'b1;
    k = -1;
    step(1);
    chk("reen_frame", 32'(fr0), 32'h1);
    chk("reen_sel", 32'(sel0), 32'h0);
    step(2);
    chk("reen_d0_sel", 32'(sel0), 32'h1);
    chk("reen_d0_seg", 32'(seg0), 32'h66);

    // asynchronous reset while lit, checked before the next clock edge
    step(3);
    chk("pre_rst_sel", 32'(sel0), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel0), 32'h0);
    chk("arst_seg", 32'(seg0), 32'h00);
    chk("arst_frame", 32'(fr0), 32'h0);
    chk("arst_seg_al", 32'(seg1), 32'h7F);
    step(2);
    @(negedge clk) rst_n = 1'b1;
    k = -1;
    step(1);
    chk("post_rst_frame", 32'(fr0), 32'h1);
    step(45);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
